// File: rtl/debug_cmd_sync_fifo.sv
// System-clock half of the JTAG debug slave: synchronises update events,
// queues DR commands and decodes them into one-hot action strobes.
module debug_cmd_sync_fifo #(
  parameter int DATA_W      = 38,
  parameter int IR_W        = 2,
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4,
  parameter int ACTION_BIT  = 35
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [DATA_W-1:0]             sr,
  input  logic [IR_W-1:0]               ir_in,
  input  logic                          vs_udr,
  input  logic                          vs_uir,
  input  logic                          cmd_ready,
  input  logic                          clr_overflow,
  output logic                          cmd_valid,
  output logic [DATA_W-1:0]             jdo,
  output logic [IR_W-1:0]               cmd_ir,
  output logic [(2**IR_W)-1:0]          take_action,
  output logic [(2**IR_W)-1:0]          take_no_action,
  output logic                          ir_update,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int NUM_CMD = 2**IR_W;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int LVL_W   = PTR_W + 1;
  localparam int ENT_W   = IR_W + DATA_W;

  logic [SYNC_STAGES-1:0] udr_sync;
  logic [SYNC_STAGES-1:0] uir_sync;
  logic                   udr_hist;
  logic                   uir_hist;
  logic                   udr_rise;
  logic                   uir_rise;

  logic [ENT_W-1:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [LVL_W-1:0]       level;
  logic                   full;
  logic                   pop;
  logic                   push;
  logic                   drop;
  logic [ENT_W-1:0]       head;
  logic [IR_W-1:0]        head_ir;
  logic                   head_act;
  logic [NUM_CMD-1:0]     lane;

  assign udr_rise = udr_sync[SYNC_STAGES-1] & ~udr_hist;
  assign uir_rise = uir_sync[SYNC_STAGES-1] & ~uir_hist;

  assign full      = (level == LVL_W'(FIFO_DEPTH));
  assign cmd_valid = (level != '0);
  assign pop       = cmd_valid & cmd_ready;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign push      = udr_rise & (~full | pop);
  assign drop      = udr_rise & full & ~pop;

  assign head     = mem[rd_ptr];
  assign head_ir  = head[ENT_W-1:DATA_W];
  assign head_act = head[ACTION_BIT];
  assign lane     = NUM_CMD'(1) << head_ir;

  assign fifo_level = level;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {ir_in, sr};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      udr_sync       <= '0;
      uir_sync       <= '0;
      udr_hist       <= 1'b0;
      uir_hist       <= 1'b0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      level          <= '0;
      jdo            <= '0;
      cmd_ir         <= '0;
      take_action    <= '0;
      take_no_action <= '0;
      ir_update      <= 1'b0;
      overflow       <= 1'b0;
    end else begin
      udr_sync  <= {udr_sync[SYNC_STAGES-2:0], vs_udr};
      uir_sync  <= {uir_sync[SYNC_STAGES-2:0], vs_uir};
      udr_hist  <= udr_sync[SYNC_STAGES-1];
      uir_hist  <= uir_sync[SYNC_STAGES-1];
      ir_update <= uir_rise;
      level     <= level + LVL_W'(push) - LVL_W'(pop);
      overflow  <= drop | (overflow & ~clr_overflow);
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
        jdo    <= head[DATA_W-1:0];
        cmd_ir <= head_ir;
      end
      take_action    <= (pop && head_act)  ? lane : '0;
      take_no_action <= (pop && !head_act) ? lane : '0;
    end
  end

endmodule

// File: tb/tb_debug_cmd_sync_fifo.sv
// Bench for debug_cmd_sync_fifo: directed plan steps, then random
// traffic, all checked against a queue-based command model.
module tb_debug_cmd_sync_fifo;

  localparam int DATA_W = 38;
  localparam int IR_W   = 2;
  localparam int S      = 2;
  localparam int D      = 4;
  localparam int AB     = 35;
  localparam int NC     = 4;

  typedef logic [IR_W+DATA_W-1:0] ent_t;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [DATA_W-1:0] sr = '0;
  logic [IR_W-1:0]   ir_in = '0;
  logic              vs_udr = 1'b0;
  logic              vs_uir = 1'b0;
  logic              cmd_ready = 1'b0;
  logic              clr_overflow = 1'b0;
  logic              cmd_valid;
  logic [DATA_W-1:0] jdo;
  logic [IR_W-1:0]   cmd_ir;
  logic [NC-1:0]     take_action;
  logic [NC-1:0]     take_no_action;
  logic              ir_update;
  logic              overflow;
  logic [2:0]        fifo_level;

  debug_cmd_sync_fifo dut (
    .clk(clk), .reset_n(reset_n), .sr(sr), .ir_in(ir_in),
    .vs_udr(vs_udr), .vs_uir(vs_uir), .cmd_ready(cmd_ready),
    .clr_overflow(clr_overflow), .cmd_valid(cmd_valid), .jdo(jdo),
    .cmd_ir(cmd_ir), .take_action(take_action),
    .take_no_action(take_no_action), .ir_update(ir_update),
    .overflow(overflow), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  ent_t              q[$];
  logic [S:0]        uh;
  logic [S:0]        ih;
  logic [DATA_W-1:0] m_jdo;
  logic [IR_W-1:0]   m_ir;
  logic [NC-1:0]     m_ta;
  logic [NC-1:0]     m_tna;
  logic              m_iru;
  logic              m_ovf;

  int errors = 0;
  int checks = 0;
  int strobe_cycles = 0;
  int iru_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    uh = '0;
    ih = '0;
    m_jdo = '0;
    m_ir = '0;
    m_ta = '0;
    m_tna = '0;
    m_iru = 1'b0;
    m_ovf = 1'b0;
  endtask

  task automatic compare_all(input string pfx);
    chk({pfx, "_cmd_valid"}, 64'(cmd_valid), 64'(q.size() != 0));
    chk({pfx, "_level"}, 64'(fifo_level), 64'(q.size()));
    chk({pfx, "_jdo"}, 64'(jdo), 64'(m_jdo));
    chk({pfx, "_cmd_ir"}, 64'(cmd_ir), 64'(m_ir));
    chk({pfx, "_take_action"}, 64'(take_action), 64'(m_ta));
    chk({pfx, "_take_no_action"}, 64'(take_no_action), 64'(m_tna));
    chk({pfx, "_ir_update"}, 64'(ir_update), 64'(m_iru));
    chk({pfx, "_overflow"}, 64'(overflow), 64'(m_ovf));
  endtask

  // Called just after a falling edge with inputs settled for the next rise.
  task automatic step(input string pfx);
    bit   push, pop, uirr, drop;
    ent_t e;
    // A sync event lands S edges after the first high sample.
    push = uh[S-1] && !uh[S];
    uirr = ih[S-1] && !ih[S];
    uh = {uh[S-1:0], vs_udr};
    ih = {ih[S-1:0], vs_uir};
    pop = (q.size() != 0) && cmd_ready;
    m_ta = '0;
    m_tna = '0;
    if (pop) begin
      e = q.pop_front();
      m_jdo = e[DATA_W-1:0];
      m_ir = e[IR_W+DATA_W-1:DATA_W];
      if (e[AB]) m_ta[m_ir] = 1'b1;
      else m_tna[m_ir] = 1'b1;
    end
    drop = push && (q.size() >= D);
    if (push && !drop) q.push_back({ir_in, sr});
    m_ovf = drop || (m_ovf && !clr_overflow);
    m_iru = uirr;
    @(posedge clk);
    #1;
    compare_all(pfx);
    if ((take_action != '0) || (take_no_action != '0)) strobe_cycles++;
    if (ir_update) iru_cnt++;
    @(negedge clk);
  endtask

  task automatic steps(input string pfx, input int n);
    for (int i = 0; i < n; i++) step(pfx);
  endtask

  task automatic udr_pulse(input string pfx);
    vs_udr = 1'b1;
    step(pfx);
    vs_udr = 1'b0;
    step(pfx);
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("rst_cmd_valid", 64'(cmd_valid), 64'd0);
    chk("rst_level", 64'(fifo_level), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    reset_n = 1'b1;
    steps("idle", 2);

    // Single take_action command
    sr = 38'h8_0000_1234;
    ir_in = 2'b01;
    cmd_ready = 1'b1;
    vs_udr = 1'b1;
    strobe_cycles = 0;
    steps("single", 6);
    vs_udr = 1'b0;
    steps("single", 3);
    chk("single_jdo", 64'(jdo), 64'h8_0000_1234);
    chk("single_strobes", 64'(strobe_cycles), 64'd1);

    // Single take_no_action command
    sr = 38'h0_1234_5678;
    ir_in = 2'b11;
    strobe_cycles = 0;
    udr_pulse("noact");
    steps("noact", 4);
    chk("noact_cmd_ir", 64'(cmd_ir), 64'd3);
    chk("noact_strobes", 64'(strobe_cycles), 64'd1);

    // Burst of five into a four-entry FIFO
    cmd_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sr = {$urandom, $urandom};
      ir_in = IR_W'(i);
      udr_pulse("burst");
    end
    steps("burst", 3);
    chk("burst_level", 64'(fifo_level), 64'd4);
    chk("burst_overflow", 64'(overflow), 64'd1);
    cmd_ready = 1'b1;
    strobe_cycles = 0;
    steps("drain", 6);
    chk("drain_strobes", 64'(strobe_cycles), 64'd4);

    // Full FIFO with push and pop on the same edge
    cmd_ready = 1'b0;
    clr_overflow = 1'b1;
    step("clr");
    clr_overflow = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sr = {$urandom, $urandom};
      ir_in = IR_W'($urandom);
      udr_pulse("fill");
    end
    steps("fill", 2);
    sr = {$urandom, $urandom};
    vs_udr = 1'b1;
    step("simul");
    vs_udr = 1'b0;
    step("simul");
    cmd_ready = 1'b1;
    step("simul");
    cmd_ready = 1'b0;
    chk("simul_level", 64'(fifo_level), 64'd4);
    chk("simul_overflow", 64'(overflow), 64'd0);

    // Overflow set and clear on the same edge: set wins
    vs_udr = 1'b1;
    step("setclr");
    vs_udr = 1'b0;
    step("setclr");
    clr_overflow = 1'b1;
    step("setclr");
    clr_overflow = 1'b0;
    chk("setclr_overflow", 64'(overflow), 64'd1);

    // Held vs_uir gives one ir_update pulse
    iru_cnt = 0;
    vs_uir = 1'b1;
    steps("uir", 10);
    vs_uir = 1'b0;
    steps("uir", 3);
    chk("uir_pulses", 64'(iru_cnt), 64'd1);
    chk("uir_level", 64'(fifo_level), 64'd4);

    // Reset mid-stream with three entries queued
    cmd_ready = 1'b1;
    step("pop1");
    cmd_ready = 1'b0;
    chk("pre_rst_level", 64'(fifo_level), 64'd3);
    vs_udr = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_cmd_valid", 64'(cmd_valid), 64'd0);
    chk("mid_rst_level", 64'(fifo_level), 64'd0);
    chk("mid_rst_jdo", 64'(jdo), 64'd0);
    chk("mid_rst_cmd_ir", 64'(cmd_ir), 64'd0);
    chk("mid_rst_overflow", 64'(overflow), 64'd0);
    chk("mid_rst_strobes", 64'({take_action, take_no_action}), 64'd0);
    chk("mid_rst_ir_update", 64'(ir_update), 64'd0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    vs_udr = 1'b0;
    steps("post_rst", 3);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      sr = {$urandom, $urandom};
      ir_in = IR_W'($urandom);
      vs_udr = ($urandom_range(0, 2) == 0);
      vs_uir = ($urandom_range(0, 5) == 0);
      cmd_ready = ($urandom_range(0, 2) == 0);
      clr_overflow = ($urandom_range(0, 7) == 0);
      step("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
